// File: rtl/line_buffer3.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer3
// Purpose  : Two-line delay buffer producing a column-aligned 3-row pixel
//            stream (top, middle, bottom) for a 3x3 window filter.
// Ports    : clk        - clock, all logic on rising edge
//            rst        - asynchronous active-high reset
//            vsync_i    - frame sync; while high, restarts line priming
//            de_i       - pixel valid; one high run is one line
//            data_i     - input pixel
//            de_o       - aligned 3-row column valid
//            data0_o    - same column, two lines earlier (top row)
//            data1_o    - same column, one line earlier (middle row)
//            data2_o    - current-line pixel (bottom row)
//            overflow_o - sticky: a line exceeded MAX_WIDTH pixels
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer3 #(
  parameter int DATA_WIDTH = 10,
  parameter int MAX_WIDTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync_i,
  input  logic                  de_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] data0_o,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [DATA_WIDTH-1:0] data2_o,
  output logic                  overflow_o
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  // The column counter must be able to reach MAX_WIDTH itself so that the
  // first excess pixel of a line can be recognised.
  localparam int CW = $clog2(MAX_WIDTH + 1);
  localparam logic [CW-1:0] MAX_COL = CW'(MAX_WIDTH);

  // Line memories: mem1 holds the previous line, mem0 the one before it.
  // Deliberately not reset.
  logic [DATA_WIDTH-1:0] mem0 [MAX_WIDTH];
  logic [DATA_WIDTH-1:0] mem1 [MAX_WIDTH];

  logic [CW-1:0]         col_q, col_d;
  logic [1:0]            lines_q, lines_d;
  logic                  de_prev_q, de_prev_d;
  logic                  de_o_q, de_o_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic [DATA_WIDTH-1:0] data2_q, data2_d;
  logic                  overflow_q, overflow_d;

  logic                  accept;
  logic                  line_end;
  logic [AW-1:0]         addr;

  assign addr = col_q[AW-1:0];

  always_comb begin
    accept     = de_i && !vsync_i && (col_q < MAX_COL);
    line_end   = de_prev_q && !de_i;

    col_d      = col_q;
    lines_d    = lines_q;
    de_prev_d  = de_i;
    de_o_d     = accept && (lines_q == 2'd2);
    data0_d    = data0_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    overflow_d = overflow_q;

    // Clearing col on every de_i=0 cycle covers the cycle after the falling
    // edge; col_q still holds the finished line's length during that edge.
    if (vsync_i || !de_i) begin
      col_d = '0;
    end else if (accept) begin
      col_d = col_q + 1'b1;
    end

    // A line counts toward priming only if it delivered at least one pixel;
    // col_q is non-zero exactly when that happened.
    if (vsync_i) begin
      lines_d = 2'd0;
    end else if (line_end && (col_q != '0) && (lines_q != 2'd2)) begin
      lines_d = lines_q + 2'd1;
    end

    if (vsync_i) begin
      overflow_d = 1'b0;
    end else if (de_i && (col_q == MAX_COL)) begin
      overflow_d = 1'b1;
    end

    // Outputs update only on accepted pixels, so all three rows stay aligned
    // and hold otherwise.
    if (accept) begin
      data2_d = data_i;
      data1_d = mem1[addr];
      data0_d = mem0[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      lines_q    <= 2'd0;
      de_prev_q  <= 1'b0;
      de_o_q     <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      lines_q    <= lines_d;
      de_prev_q  <= de_prev_d;
      de_o_q     <= de_o_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      overflow_q <= overflow_d;
    end
  end

  // Read-before-write: the old mem1 entry shifts into mem0 while the new
  // pixel replaces it; both reads above see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem0[addr] <= mem1[addr];
      mem1[addr] <= data_i;
    end
  end

  assign de_o       = de_o_q;
  assign data0_o    = data0_q;
  assign data1_o    = data1_q;
  assign data2_o    = data2_q;
  assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_line_buffer3.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_buffer3
// Purpose  : Self-checking bench for line_buffer3 (DATA_WIDTH=8,
//            MAX_WIDTH=16). Expected outputs are queued as stimulus is
//            driven and compared one clock later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_buffer3;

  localparam int DW = 8;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync_i = 1'b0;
  logic          de_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          de_o;
  logic [DW-1:0] data0_o, data1_o, data2_o;
  logic          overflow_o;

  line_buffer3 #(.DATA_WIDTH(DW), .MAX_WIDTH(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync_i    (vsync_i),
    .de_i       (de_i),
    .data_i     (data_i),
    .de_o       (de_o),
    .data0_o    (data0_o),
    .data1_o    (data1_o),
    .data2_o    (data2_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic          de;
    logic [DW-1:0] d0, d1, d2;
    logic          k0, k1;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: history of the last two lines per column, with a
  // "known" flag so never-written memory locations are not compared.
  logic [DW-1:0] m0 [MW];
  logic [DW-1:0] m1 [MW];
  logic          k0m [MW];
  logic          k1m [MW];
  int            mcol, mlines;
  logic          movf, mde_prev;
  logic [DW-1:0] o0, o1, o2;
  logic          ko0, ko1;

  task automatic model_reset();
    mcol = 0; mlines = 0; movf = 1'b0; mde_prev = 1'b0;
    o0 = '0; o1 = '0; o2 = '0; ko0 = 1'b1; ko1 = 1'b1;
  endtask

  // Drive one cycle of input and queue what the DUT must show after the edge.
  task automatic cycle(input logic vs, input logic de, input logic [DW-1:0] d);
    logic acc, fall, ede;
    exp_t e;
    @(negedge clk);
    vsync_i = vs; de_i = de; data_i = d;
    acc  = de && !vs && (mcol < MW);
    fall = mde_prev && !de;
    ede  = acc && (mlines == 2);
    if (acc) begin
      o2 = d; o1 = m1[mcol]; o0 = m0[mcol]; ko1 = k1m[mcol]; ko0 = k0m[mcol];
      m0[mcol] = m1[mcol]; k0m[mcol] = k1m[mcol];
      m1[mcol] = d;        k1m[mcol] = 1'b1;
    end
    if (vs) movf = 1'b0;
    else if (de && mcol == MW) movf = 1'b1;
    if (vs) mlines = 0;
    else if (fall && mcol != 0 && mlines < 2) mlines++;
    if (vs || !de) mcol = 0;
    else if (acc) mcol++;
    mde_prev = de;
    e.de = ede; e.d0 = o0; e.d1 = o1; e.d2 = o2; e.k0 = ko0; e.k1 = ko1; e.ovf = movf;
    sb_q.push_back(e);
  endtask

  task automatic send_line(input logic [DW-1:0] base, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, base + DW'(k));
    cycle(1'b0, 1'b0, '0);
  endtask

  task automatic vsync_pulse(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_de"},   {31'd0, de_o},       32'd0);
    check({tag, "_d0"},   {24'd0, data0_o},    32'd0);
    check({tag, "_d1"},   {24'd0, data1_o},    32'd0);
    check({tag, "_d2"},   {24'd0, data2_o},    32'd0);
    check({tag, "_ovf"},  {31'd0, overflow_o}, 32'd0);
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("de_o", {31'd0, de_o}, {31'd0, mon_e.de});
      check("overflow_o", {31'd0, overflow_o}, {31'd0, mon_e.ovf});
      check("data2_o", {24'd0, data2_o}, {24'd0, mon_e.d2});
      if (mon_e.k1) check("data1_o", {24'd0, data1_o}, {24'd0, mon_e.d1});
      if (mon_e.k0) check("data0_o", {24'd0, data0_o}, {24'd0, mon_e.d0});
    end
  end

  initial begin
    for (int i = 0; i < MW; i++) begin
      m0[i] = '0; m1[i] = '0; k0m[i] = 1'b0; k1m[i] = 1'b0;
    end
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Priming, then scrolling
    vsync_pulse(1);
    send_line(8'h10, 4);
    send_line(8'h20, 4);
    send_line(8'h30, 4);
    send_line(8'h40, 4);

    // Vsync mid-frame: two lines of no output, then output resumes
    vsync_pulse(2);
    send_line(8'h50, 4);
    send_line(8'h60, 4);
    send_line(8'h70, 4);

    // Overflow with an 18-pixel line, then full and short lines
    vsync_pulse(1);
    send_line(8'h80, 16);
    send_line(8'hA0, 18);
    send_line(8'hC0, 16);
    send_line(8'hD0, 4);
    send_line(8'hE0, 16);
    vsync_pulse(1);

    // de_i together with vsync_i: pixel dropped, priming restarts
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b0, 1'b0, '0);
    send_line(8'h11, 3);
    send_line(8'h22, 3);
    send_line(8'h33, 3);

    // Asynchronous reset in the middle of an output line
    vsync_pulse(1);
    send_line(8'h01, 5);
    send_line(8'h02, 5);
    cycle(1'b0, 1'b1, 8'h03);
    cycle(1'b0, 1'b1, 8'h13);
    @(posedge clk);
    #3;
    check("pre_rst_de", {31'd0, de_o}, 32'd1);
    rst = 1'b1; de_i = 1'b0; vsync_i = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    send_line(8'h04, 5);
    send_line(8'h05, 5);
    send_line(8'h06, 5);

    repeat (3) @(posedge clk);
    #2 check("sb_drain", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
